// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: address word, cache line and the memory
// arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

    function automatic lc3b_word line_align(input lc3b_word addr);
        return {addr[15:4], 4'b0000};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter advancing by 0..2 per cycle; clears only on reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (sum[WIDTH]) begin
            count <= '1;
        end else begin
            count <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single physical-memory line port between I-cache and D-cache,
// D first with a starvation guard for fetch; grant is held until pmem_resp.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         icache_read,
    input  logic [15:0]  icache_address,
    output logic [127:0] icache_rdata,
    output logic         icache_resp,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [15:0]  dcache_address,
    input  logic [127:0] dcache_wdata,
    output logic [127:0] dcache_rdata,
    output logic         dcache_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  wait_count
);

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    lc3b_arb_state state, next_state;
    logic [3:0]    d_streak;
    logic          is_write;
    logic          d_req;
    logic          grant_i, grant_d;
    logic          i_wait, d_wait;
    logic [1:0]    wait_inc;

    assign d_req        = dcache_read | dcache_write;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        unique case (state)
            IDLE: begin
                // D wins unless fetch has already lost STARVE_LIMIT times in a row.
                if (d_req && !(icache_read && d_streak == STREAK_MAX)) begin
                    next_state = SERVE_D;
                    grant_d    = 1'b1;
                end else if (icache_read) begin
                    next_state = SERVE_I;
                    grant_i    = 1'b1;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    icache_resp = 1'b1;
                    next_state  = IDLE;
                end
            end
            SERVE_D: begin
                pmem_write = is_write;
                pmem_read  = ~is_write;
                if (pmem_resp) begin
                    dcache_resp = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the 128-bit write-data register is reset along with the control
    // state so pmem_wdata reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            d_streak     <= '0;
            is_write     <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state <= next_state;
            if (grant_i) begin
                pmem_address <= line_align(icache_address);
                is_write     <= 1'b0;
                d_streak     <= '0;
            end
            if (grant_d) begin
                pmem_address <= line_align(dcache_address);
                is_write     <= dcache_write;
                if (dcache_write) begin
                    pmem_wdata <= dcache_wdata;
                end
                if (icache_read && d_streak != STREAK_MAX) begin
                    d_streak <= d_streak + 4'd1;
                end
            end
        end
    end

    // A requester waits in any cycle it asserts but is not the one being served.
    always_comb begin
        i_wait   = icache_read && (state != SERVE_I);
        d_wait   = d_req && (state != SERVE_D);
        wait_inc = {1'b0, i_wait} + {1'b0, d_wait};
    end

    sat_counter #(.WIDTH(16)) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .count (wait_count)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard of expected
// grants/responses, and hand sequences for arbitration, latching and reset.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         icache_read = 1'b0;
    logic [15:0]  icache_address = '0;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read = 1'b0;
    logic         dcache_write = 1'b0;
    logic [15:0]  dcache_address = '0;
    logic [127:0] dcache_wdata = '0;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [15:0]  wait_count;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .wait_count     (wait_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as expected", name);
    endtask

    function automatic logic [127:0] line_for(input logic [15:0] a);
        return {4{a, ~a}};
    endfunction

    // Physical memory: answers mem_latency cycles after the strobe first appears.
    int mem_latency = 0;
    int lat_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pmem_resp = 1'b0;
            lat_cnt   = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            lat_cnt   = 0;
        end else if (pmem_read || pmem_write) begin
            if (lat_cnt >= mem_latency) begin
                pmem_resp  = 1'b1;
                pmem_rdata = line_for(pmem_address);
            end else begin
                lat_cnt++;
            end
        end
    end

    typedef struct {
        bit           is_i;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    bit   prev_strobe = 1'b0;
    bit   sb_enable = 1'b1;
    int   resp_count = 0;

    // Scoreboard monitor, sampling 2 time units after the falling edge.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            cur_valid   = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (sb_enable && (pmem_read || pmem_write) && !prev_strobe) begin
                if (sb.size() == 0) begin
                    fail_now("grant_unexpected");
                end else begin
                    cur       = sb.pop_front();
                    cur_valid = 1'b1;
                    check("grant_addr", pmem_address, cur.addr);
                    check("grant_write", pmem_write, cur.wr);
                    check("grant_read", pmem_read, !cur.wr);
                    if (cur.wr) check("grant_wdata", pmem_wdata, cur.wdata);
                end
            end
            if (icache_resp || dcache_resp) begin
                resp_count++;
                if (sb_enable) begin
                    if (!cur_valid) begin
                        fail_now("resp_unexpected");
                    end else begin
                        check("resp_icache", icache_resp, cur.is_i);
                        check("resp_dcache", dcache_resp, !cur.is_i);
                        if (!cur.wr)
                            check("resp_rdata", cur.is_i ? icache_rdata : dcache_rdata, line_for(cur.addr));
                        cur_valid = 1'b0;
                    end
                end
            end
            prev_strobe = pmem_read || pmem_write;
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    // Run until every requester has seen its resp, dropping each request on its resp.
    task automatic serve(input int budget);
        int n = 0;
        while ((icache_read || dcache_read || dcache_write) && n < budget) begin
            tick();
            n++;
            if (icache_resp) icache_read = 1'b0;
            if (dcache_resp) begin
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end
        end
        if (icache_read || dcache_read || dcache_write) begin
            fail_now("serve_timeout");
            icache_read  = 1'b0;
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
        end
        tick();
    endtask

    typedef struct {
        bit           is_i;
        bit           rd;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           latency;
        bit           exp_wr;
        logic [15:0]  exp_addr;
    } vec_t;

    localparam int NV = 6;
    vec_t vec[NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]  w0;
        logic [127:0] wd1, wd2;
        int           r0;
        int           n;

        vec[0] = '{1'b1, 1'b1, 1'b0, 16'h1236, '0, 3, 1'b0, 16'h1230};
        vec[1] = '{1'b0, 1'b1, 1'b0, 16'hABCF, '0, 0, 1'b0, 16'hABC0};
        vec[2] = '{1'b0, 1'b0, 1'b1, 16'h8000, {4{32'hDEAD_BEEF}}, 2, 1'b1, 16'h8000};
        vec[3] = '{1'b0, 1'b1, 1'b1, 16'h00F7, {2{64'h0123_4567_89AB_CDEF}}, 1, 1'b1, 16'h00F0};
        vec[4] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, '0, 1, 1'b0, 16'hFFF0};
        vec[5] = '{1'b0, 1'b0, 1'b1, 16'h000C, {8{16'hA5C3}}, 0, 1'b1, 16'h0000};

        // Reset state, during and after reset.
        repeat (2) @(negedge clk);
        #3;
        check("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rst_resps", {icache_resp, dcache_resp}, 2'b00);
        rst_n = 1'b1;
        tick();
        check("idle_strobes", {pmem_read, pmem_write}, 2'b00);
        check("idle_resps", {icache_resp, dcache_resp}, 2'b00);
        check("idle_address", pmem_address, 16'h0000);
        check("idle_wdata", pmem_wdata, 128'h0);
        check("idle_wait_count", wait_count, 16'h0000);
        check("idle_rdata", {icache_rdata[63:0], dcache_rdata[63:0]}, 128'h0);

        // Single-requester vectors.
        for (int k = 0; k < NV; k++) begin
            w0          = wait_count;
            mem_latency = vec[k].latency;
            sb.push_back('{vec[k].is_i, vec[k].exp_wr, vec[k].exp_addr, vec[k].wdata});
            if (vec[k].is_i) begin
                icache_read    = 1'b1;
                icache_address = vec[k].addr;
            end else begin
                dcache_read    = vec[k].rd;
                dcache_write   = vec[k].wr;
                dcache_address = vec[k].addr;
                dcache_wdata   = vec[k].wdata;
            end
            serve(40);
            check($sformatf("vec%0d_idle_after", k), {pmem_read, pmem_write}, 2'b00);
            check($sformatf("vec%0d_wait_delta", k), wait_count - w0, 16'd1);
        end

        // Simultaneous I read and D write: D first, I after one idle cycle.
        mem_latency = 1;
        w0  = wait_count;
        wd1 = {4{32'h8000_CAFE}};
        sb.push_back('{1'b0, 1'b1, 16'h8000, wd1});
        sb.push_back('{1'b1, 1'b0, 16'h5550, 128'h0});
        icache_read    = 1'b1;
        icache_address = 16'h5554;
        dcache_write   = 1'b1;
        dcache_address = 16'h8000;
        dcache_wdata   = wd1;
        serve(60);
        check("both_wait_delta", wait_count - w0, 16'd5);
        check("both_sb_drained", sb.size(), 0);

        // Starvation guard: both held high, expect D,D,D,D,I twice over.
        mem_latency = 0;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) sb.push_back('{1'b0, 1'b0, 16'h3000, 128'h0});
            sb.push_back('{1'b1, 1'b0, 16'h0100, 128'h0});
        end
        icache_read    = 1'b1;
        icache_address = 16'h0104;
        dcache_read    = 1'b1;
        dcache_address = 16'h300A;
        r0 = resp_count;
        n  = 0;
        while (resp_count - r0 < 10 && n < 100) begin
            tick();
            n++;
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        check("starve_resp_count", resp_count - r0, 10);
        tick();
        tick();
        check("starve_sb_drained", sb.size(), 0);

        // Requester address/data change after grant must not reach pmem.
        mem_latency = 5;
        wd1 = {4{32'h1111_2222}};
        wd2 = {4{32'h9999_8888}};
        sb.push_back('{1'b0, 1'b1, 16'h4A50, wd1});
        dcache_write   = 1'b1;
        dcache_address = 16'h4A5C;
        dcache_wdata   = wd1;
        tick();
        dcache_address = 16'h7770;
        dcache_wdata   = wd2;
        tick();
        tick();
        check("latched_address", pmem_address, 16'h4A50);
        check("latched_wdata", pmem_wdata, wd1);
        serve(40);

        // Asynchronous reset in the middle of a D write.
        mem_latency = 20;
        wd1 = {4{32'h2222_3333}};
        sb.push_back('{1'b0, 1'b1, 16'h2220, wd1});
        dcache_write   = 1'b1;
        dcache_address = 16'h2228;
        dcache_wdata   = wd1;
        tick();
        tick();
        tick();
        check("pre_reset_write", pmem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_strobes", {pmem_read, pmem_write}, 2'b00);
        dcache_write = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_strobes", {pmem_read, pmem_write}, 2'b00);
        check("post_reset_wait_count", wait_count, 16'h0000);
        check("post_reset_address", pmem_address, 16'h0000);
        check("post_reset_wdata", pmem_wdata, 128'h0);
        mem_latency = 1;
        sb.push_back('{1'b1, 1'b0, 16'h0040, 128'h0});
        icache_read    = 1'b1;
        icache_address = 16'h004E;
        serve(40);
        check("post_reset_sb_drained", sb.size(), 0);

        // Saturation of wait_count with both requesters contending.
        sb_enable   = 1'b0;
        mem_latency = 0;
        icache_read = 1'b1;
        dcache_read = 1'b1;
        n = 0;
        while (wait_count < 16'hFFF0 && n < 50000) begin
            tick();
            n++;
        end
        check("sat_reached_near_max", wait_count >= 16'hFFF0, 1'b1);
        repeat (20) tick();
        check("sat_at_max", wait_count, 16'hFFFF);
        repeat (20) tick();
        check("sat_no_wrap", wait_count, 16'hFFFF);
        icache_read = 1'b0;
        dcache_read = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
